// File: rtl/rx_rs_fault_sync_pkg.sv
// rtl/rx_rs_fault_sync_pkg.sv - shared constants, FSM types and per-column fault step for the receive RS
package rx_rs_pkg;

   localparam logic [1:0] LF_OK     = 2'b00;
   localparam logic [1:0] LF_LOCAL  = 2'b01;
   localparam logic [1:0] LF_REMOTE = 2'b10;

   localparam logic [7:0] XGMII_IDLE = 8'h07;
   localparam logic [7:0] XGMII_SEQ  = 8'h9C;
   localparam logic [7:0] SEQ_LOCAL  = 8'h01;
   localparam logic [7:0] SEQ_REMOTE = 8'h02;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_COUNT = 2'd1,
      ST_FAULT = 2'd2
   } fsm_state_e;

   typedef struct packed {
      fsm_state_e state;
      logic [3:0] seq_cnt;
      logic [1:0] last_type;
      logic [9:0] col_cnt;
      logic [1:0] link_fault;
   } rs_ctx_t;

   localparam rs_ctx_t CTX_RESET = '{ST_INIT, 4'd0, 2'd0, 10'd0, LF_OK};

   // Advance the link fault state by one column; chained once per column within a cycle.
   function automatic rs_ctx_t rs_step(input rs_ctx_t c, input logic v, input logic [1:0] t,
                                       input logic [3:0] thresh, input logic [9:0] window);
      rs_ctx_t n;
      n = c;
      case (c.state)
         ST_INIT: begin
            if (v) begin
               n.last_type = t;
               n.seq_cnt   = 4'd1;
               n.col_cnt   = 10'd0;
               n.state     = ST_COUNT;
            end
         end
         ST_COUNT, ST_FAULT: begin
            if (v) begin
               n.col_cnt = 10'd0;
               if (t != c.last_type) begin
                  n.last_type = t;
                  n.seq_cnt   = 4'd1;
               end else if (c.seq_cnt != thresh) begin
                  n.seq_cnt = c.seq_cnt + 4'd1;
               end
               // A new type only overrides the reported fault once it reaches the threshold.
               if (n.seq_cnt == thresh) begin
                  n.link_fault = n.last_type;
                  n.state      = ST_FAULT;
               end
            end else begin
               if (c.col_cnt != window) n.col_cnt = c.col_cnt + 10'd1;
               if (n.col_cnt == window) begin
                  n.seq_cnt    = 4'd0;
                  n.link_fault = LF_OK;
                  n.state      = ST_INIT;
               end
            end
         end
         default: n = CTX_RESET;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/rx_rs_fault_sync_if.sv
// rtl/rx_rs_fault_sync_if.sv - XGMII receive in/out bundle between capture, RS and receive engine
interface rx_rs_fault_sync_if #(parameter int LANES = 8);
   localparam int NCOL = LANES / 4;

   logic [LANES*8-1:0] rxd_in;
   logic [LANES-1:0]   rxc_in;
   logic [LANES*8-1:0] rxd_out;
   logic [LANES-1:0]   rxc_out;
   logic [1:0]         link_fault;
   logic [NCOL-1:0]    seq_det;

   modport master (output rxd_in, rxc_in, input rxd_out, rxc_out, link_fault, seq_det);
   modport slave  (input rxd_in, rxc_in, output rxd_out, rxc_out, link_fault, seq_det);
endinterface

// File: rtl/rx_rs_seq_detect.sv
// rtl/rx_rs_seq_detect.sv - combinational fault sequence ordered set detector for one 4-lane column
module rx_rs_seq_detect
   import rx_rs_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic [3:0]  i_ctrl,
   output logic        o_valid,
   output logic [1:0]  o_type
);
   logic w_hdr;
   logic w_local;
   logic w_remote;

   assign w_hdr    = (i_ctrl == 4'b0001) && (i_data[7:0] == XGMII_SEQ) && (i_data[23:8] == 16'h0000);
   assign w_local  = (i_data[31:24] == SEQ_LOCAL);
   assign w_remote = (i_data[31:24] == SEQ_REMOTE);
   assign o_valid  = w_hdr && (w_local || w_remote);
   assign o_type   = w_remote ? LF_REMOTE : LF_LOCAL;
endmodule

// File: rtl/rx_rs_fault_sync.sv
// rtl/rx_rs_fault_sync.sv - receive RS: registered data path plus link fault FSM; RX_RS_IDLE_REPLACE_EN forces idle while faulted
module rx_rs_fault_sync
   import rx_rs_pkg::*;
#(
   parameter int LANES        = 8,
   parameter int FAULT_THRESH = 4,
   parameter int COL_WINDOW   = 128
)(
   input  logic              rxclk,
   input  logic              reset,
   rx_rs_fault_sync_if.slave rs
);
   localparam int         NCOL      = LANES / 4;
   localparam logic [3:0] LP_THRESH = 4'(FAULT_THRESH);
   localparam logic [9:0] LP_WINDOW = 10'(COL_WINDOW);

   logic [NCOL-1:0]    w_valid;
   logic [1:0]         w_type [NCOL];
   rs_ctx_t            w_ctx_next;
   logic [LANES*8-1:0] w_rxd_next;
   logic [LANES-1:0]   w_rxc_next;

   rs_ctx_t            r_ctx;
   logic [LANES*8-1:0] r_rxd;
   logic [LANES-1:0]   r_rxc;
   logic [NCOL-1:0]    r_seq_det;

   for (genvar k = 0; k < NCOL; k++) begin : g_col
      rx_rs_seq_detect u_det (
         .i_data  (rs.rxd_in[32*k +: 32]),
         .i_ctrl  (rs.rxc_in[4*k +: 4]),
         .o_valid (w_valid[k]),
         .o_type  (w_type[k])
      );
   end

   // Next FSM state: apply columns 0..NCOL-1 in order, each seeing the previous column's result.
   always_comb begin
      w_ctx_next = r_ctx;
      for (int k = 0; k < NCOL; k++) begin
         w_ctx_next = rs_step(w_ctx_next, w_valid[k], w_type[k], LP_THRESH, LP_WINDOW);
      end
   end

   // Next output data: pass-through, or idle columns while the next-state fault is active.
   always_comb begin
      w_rxd_next = rs.rxd_in;
      w_rxc_next = rs.rxc_in;
`ifdef RX_RS_IDLE_REPLACE_EN
      if (w_ctx_next.link_fault != LF_OK) begin
         w_rxd_next = {LANES{XGMII_IDLE}};
         w_rxc_next = '1;
      end
`endif
   end

   // State and output registers; reset presents idle and clears the fault.
   always_ff @(posedge rxclk) begin
      if (reset) begin
         r_ctx     <= CTX_RESET;
         r_rxd     <= {LANES{XGMII_IDLE}};
         r_rxc     <= '1;
         r_seq_det <= '0;
      end else begin
         r_ctx     <= w_ctx_next;
         r_rxd     <= w_rxd_next;
         r_rxc     <= w_rxc_next;
         r_seq_det <= w_valid;
      end
   end

   assign rs.rxd_out    = r_rxd;
   assign rs.rxc_out    = r_rxc;
   assign rs.link_fault = r_ctx.link_fault;
   assign rs.seq_det    = r_seq_det;
endmodule
